// File: rtl/rv32_decode_stage.sv
// RV32IM decode stage: instruction FIFO feeding a single registered decoded micro-op,
// with valid/ready on both sides, synchronous flush and illegal-encoding detection.
module rv32_decode_stage #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int M_EXT      = 1,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic [XLEN-1:0]  in_pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [4:0]       out_rs1_o,
    output logic [4:0]       out_rs2_o,
    output logic [4:0]       out_rd_o,
    output logic [31:0]      out_imm_o,
    output logic [1:0]       out_src_sel_o,
    output logic [4:0]       out_alu_op_o,
    output logic [3:0]       out_lsu_op_o,
    output logic [2:0]       out_br_op_o,
    output logic             out_is_branch_o,
    output logic             out_is_cond_o,
    output logic             out_reg_w_o,
    output logic             out_mem_w_o,
    output logic             out_illegal_o,
    output logic [CNT_W-1:0] fifo_count_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [1:0]  src_sel;
        logic [4:0]  alu_op;
        logic [3:0]  lsu_op;
        logic [2:0]  br_op;
        logic        is_branch;
        logic        is_cond;
        logic        reg_w;
        logic        mem_w;
        logic        illegal;
    } uop_t;

    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    base_alu = 5'd0;
            3'd1:    base_alu = 5'd2;
            3'd2:    base_alu = 5'd3;
            3'd3:    base_alu = 5'd4;
            3'd4:    base_alu = 5'd5;
            3'd5:    base_alu = 5'd6;
            3'd6:    base_alu = 5'd8;
            default: base_alu = 5'd9;
        endcase
    endfunction

    logic [31:0]     instr_mem_r [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem_r    [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             valid_r;
    logic [XLEN-1:0]  pc_r;
    uop_t             uop_r;
    logic             push_s, load_s, ill_s;
    logic [31:0]      head_s, imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s;
    logic [2:0]       f3_s;
    logic [6:0]       f7_s;
    uop_t             raw_s, dec_s;

    assign in_ready_o = (count_r < CNT_W'(FIFO_DEPTH));
    assign push_s     = in_valid_i && in_ready_o;
    assign load_s     = (count_r != '0) && (!valid_r || out_ready_i);
    assign head_s     = instr_mem_r[rd_ptr_r];
    assign f3_s       = head_s[14:12];
    assign f7_s       = head_s[31:25];
    assign imm_i_s    = {{20{head_s[31]}}, head_s[31:20]};
    assign imm_s_s    = {{20{head_s[31]}}, head_s[31:25], head_s[11:7]};
    assign imm_b_s    = {{19{head_s[31]}}, head_s[31], head_s[7], head_s[30:25], head_s[11:8], 1'b0};
    assign imm_j_s    = {{11{head_s[31]}}, head_s[31], head_s[19:12], head_s[20], head_s[30:21], 1'b0};
    assign imm_u_s    = {head_s[31:12], 12'h000};

    // Raw decode of the FIFO head; illegal cases are flagged in ill_s
    always_comb begin
        raw_s = '0;
        ill_s = 1'b0;
        case (head_s[6:0])
            7'b0110011: begin
                raw_s.rs1 = head_s[19:15]; raw_s.rs2 = head_s[24:20]; raw_s.rd = head_s[11:7];
                raw_s.reg_w = 1'b1;
                case (f7_s)
                    7'h00: raw_s.alu_op = base_alu(f3_s);
                    7'h20: begin
                        if (f3_s == 3'd0)      raw_s.alu_op = 5'd1;
                        else if (f3_s == 3'd5) raw_s.alu_op = 5'd7;
                        else                   ill_s = 1'b1;
                    end
                    7'h01: begin
                        if (M_EXT != 0) raw_s.alu_op = 5'd10 + {2'b00, f3_s};
                        else            ill_s = 1'b1;
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            7'b0010011: begin
                raw_s.rs1 = head_s[19:15]; raw_s.rd = head_s[11:7]; raw_s.imm = imm_i_s;
                raw_s.src_sel = 2'd1; raw_s.reg_w = 1'b1;
                raw_s.alu_op = base_alu(f3_s);
                if (f3_s == 3'd1) begin
                    ill_s = (f7_s != 7'h00);
                end else if (f3_s == 3'd5) begin
                    ill_s = (f7_s != 7'h00) && (f7_s != 7'h20);
                    raw_s.alu_op = (f7_s == 7'h20) ? 5'd7 : 5'd6;
                end else begin
                    ill_s = 1'b0;
                end
            end
            7'b0000011: begin
                raw_s.rs1 = head_s[19:15]; raw_s.rd = head_s[11:7]; raw_s.imm = imm_i_s;
                raw_s.src_sel = 2'd1; raw_s.reg_w = 1'b1;
                case (f3_s)
                    3'd0:    raw_s.lsu_op = 4'd1;
                    3'd1:    raw_s.lsu_op = 4'd2;
                    3'd2:    raw_s.lsu_op = 4'd3;
                    3'd4:    raw_s.lsu_op = 4'd4;
                    3'd5:    raw_s.lsu_op = 4'd5;
                    default: ill_s = 1'b1;
                endcase
            end
            7'b0100011: begin
                raw_s.rs1 = head_s[19:15]; raw_s.rs2 = head_s[24:20]; raw_s.imm = imm_s_s;
                raw_s.src_sel = 2'd1; raw_s.mem_w = 1'b1;
                case (f3_s)
                    3'd0:    raw_s.lsu_op = 4'd6;
                    3'd1:    raw_s.lsu_op = 4'd7;
                    3'd2:    raw_s.lsu_op = 4'd8;
                    default: ill_s = 1'b1;
                endcase
            end
            7'b1100011: begin
                raw_s.rs1 = head_s[19:15]; raw_s.rs2 = head_s[24:20]; raw_s.imm = imm_b_s;
                raw_s.is_branch = 1'b1; raw_s.is_cond = 1'b1;
                case (f3_s)
                    3'd0:    raw_s.br_op = 3'd1;
                    3'd1:    raw_s.br_op = 3'd2;
                    3'd4:    raw_s.br_op = 3'd3;
                    3'd5:    raw_s.br_op = 3'd4;
                    3'd6:    raw_s.br_op = 3'd5;
                    3'd7:    raw_s.br_op = 3'd6;
                    default: ill_s = 1'b1;
                endcase
            end
            7'b1101111: begin
                raw_s.rd = head_s[11:7]; raw_s.imm = imm_j_s; raw_s.src_sel = 2'd2;
                raw_s.is_branch = 1'b1; raw_s.reg_w = 1'b1;
            end
            7'b1100111: begin
                raw_s.rs1 = head_s[19:15]; raw_s.rd = head_s[11:7]; raw_s.imm = imm_i_s;
                raw_s.src_sel = 2'd1; raw_s.is_branch = 1'b1; raw_s.reg_w = 1'b1;
                ill_s = (f3_s != 3'd0);
            end
            7'b0110111: begin
                raw_s.rd = head_s[11:7]; raw_s.imm = imm_u_s; raw_s.src_sel = 2'd1; raw_s.reg_w = 1'b1;
            end
            7'b0010111: begin
                raw_s.rd = head_s[11:7]; raw_s.imm = imm_u_s; raw_s.src_sel = 2'd2; raw_s.reg_w = 1'b1;
            end
            7'b0001111, 7'b1110011: raw_s = '0;
            default: ill_s = 1'b1;
        endcase
    end

    // Illegal encodings carry no side effects; writes to x0 are suppressed
    always_comb begin
        dec_s = raw_s;
        dec_s.reg_w = raw_s.reg_w && (raw_s.rd != 5'd0);
        if (ill_s) begin
            dec_s = '0;
            dec_s.illegal = 1'b1;
        end else begin
            dec_s.illegal = 1'b0;
        end
    end

    // FIFO storage; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_s && !flush_i) begin
            instr_mem_r[wr_ptr_r] <= in_instr_i;
            pc_mem_r[wr_ptr_r]    <= in_pc_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (load_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, load_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Decoded output register; holds while execute stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            uop_r   <= '0;
        end else if (flush_i) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r <= 1'b1;
            pc_r    <= pc_mem_r[rd_ptr_r];
            uop_r   <= dec_s;
        end else if (out_ready_i) begin
            valid_r <= 1'b0;
        end
    end

    assign out_valid_o     = valid_r;
    assign out_pc_o        = pc_r;
    assign out_rs1_o       = uop_r.rs1;
    assign out_rs2_o       = uop_r.rs2;
    assign out_rd_o        = uop_r.rd;
    assign out_imm_o       = uop_r.imm;
    assign out_src_sel_o   = uop_r.src_sel;
    assign out_alu_op_o    = uop_r.alu_op;
    assign out_lsu_op_o    = uop_r.lsu_op;
    assign out_br_op_o     = uop_r.br_op;
    assign out_is_branch_o = uop_r.is_branch;
    assign out_is_cond_o   = uop_r.is_cond;
    assign out_reg_w_o     = uop_r.reg_w;
    assign out_mem_w_o     = uop_r.mem_w;
    assign out_illegal_o   = uop_r.illegal;
    assign fifo_count_o    = count_r;
endmodule
